// File: rtl/dead_time_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : dead_time_pkg                                              |
// | Description : Shared types and constants for the dead-time gate driver.  |
// |               Holds the per-leg state encoding and the reset defaults    |
// |               for the dead-time register.                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package dead_time_pkg;

  // Width of the dead-time value, in clock cycles.
  localparam int          DT_W_DEFAULT   = 8;
  // Dead time in force until the first dt_load after reset.
  localparam int unsigned DT_DEFAULT_VAL = 20;

  // Per-leg commutation state.
  typedef enum logic [2:0] {
    OFF  = 3'd0,  // both switches off, waiting for enable
    DT_H = 3'd1,  // dead time before turning the high side on
    HI   = 3'd2,  // high side on
    DT_L = 3'd3,  // dead time before turning the low side on
    LO   = 3'd4   // low side on
  } leg_state_t;

endpackage
`default_nettype wire

// File: rtl/dead_time_leg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dead_time_leg                                              |
// | Description : One inverter phase leg. Registers the PWM command, runs    |
// |               the commutation FSM with its dead-time counter and drives  |
// |               registered complementary gate outputs.                     |
// | Ports       : clk, reset (async, active-low), en, kill, dt (effective    |
// |               dead time, never zero), v_in (PWM command), g_hi, g_lo.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dead_time_leg
  import dead_time_pkg::*;
#(
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            kill,
  input  logic [DT_W-1:0] dt,
  input  logic            v_in,
  output logic            g_hi,
  output logic            g_lo
);

  logic            r_v_q;
  leg_state_t      r_state;
  leg_state_t      w_state_next;
  logic [DT_W-1:0] r_cnt;
  logic [DT_W-1:0] w_cnt_next;
  logic [DT_W-1:0] w_dt_m1;

  // dt is guaranteed non-zero by the top, so this never wraps.
  assign w_dt_m1 = dt - DT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v_q   <= 1'b0;
      r_state <= OFF;
      r_cnt   <= '0;
      g_hi    <= 1'b0;
      g_lo    <= 1'b0;
    end else begin
      r_v_q   <= v_in;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // Gates follow the state being entered so they switch on the same edge.
      g_hi    <= (w_state_next == HI);
      g_lo    <= (w_state_next == LO);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (!en || kill) begin
      w_state_next = OFF;
    end else begin
      case (r_state)
        OFF: begin
          w_state_next = r_v_q ? DT_H : DT_L;
          w_cnt_next   = w_dt_m1;
        end
        DT_H: begin
          // Command withdrawn: the low side was the last one on, so it may
          // return immediately without another dead time.
          if (!r_v_q)              w_state_next = LO;
          else if (r_cnt == '0)    w_state_next = HI;
          else                     w_cnt_next   = r_cnt - DT_W'(1);
        end
        HI: begin
          if (!r_v_q) begin
            w_state_next = DT_L;
            w_cnt_next   = w_dt_m1;
          end
        end
        DT_L: begin
          if (r_v_q)               w_state_next = HI;
          else if (r_cnt == '0)    w_state_next = LO;
          else                     w_cnt_next   = r_cnt - DT_W'(1);
        end
        LO: begin
          if (r_v_q) begin
            w_state_next = DT_H;
            w_cnt_next   = w_dt_m1;
          end
        end
        default: w_state_next = OFF;
      endcase
    end
  end

  // Shoot-through guard: both switches of a leg must never be on together.
  a_no_overlap: assert property (@(posedge clk) disable iff (!reset) !(g_hi && g_lo));

endmodule
`default_nettype wire

// File: rtl/dead_time_gate_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dead_time_gate_driver                                      |
// | Description : Three-phase complementary gate driver with programmable    |
// |               dead time. Sits between the SPWM modulator and the gate    |
// |               driver pins. Owns the dead-time register and, optionally,  |
// |               the fault trip latch.                                      |
// | Ports       : clk, reset (async, active-low), en, dead_time, dt_load,    |
// |               Va/Vb/Vc commands, ga/gb/gc _hi/_lo registered gates.      |
// |               With GATE_TRIP_EN defined: trip (in), tripped (out).       |
// | Macro       : GATE_TRIP_EN enables the fault trip input and latch.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module dead_time_gate_driver
  import dead_time_pkg::*;
#(
  parameter int              DT_W       = DT_W_DEFAULT,
  parameter logic [DT_W-1:0] DT_DEFAULT = DT_W'(DT_DEFAULT_VAL)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [DT_W-1:0] dead_time,
  input  logic            dt_load,
  input  logic            Va,
  input  logic            Vb,
  input  logic            Vc,
  output logic            ga_hi,
  output logic            ga_lo,
  output logic            gb_hi,
  output logic            gb_lo,
  output logic            gc_hi,
  output logic            gc_lo
`ifdef GATE_TRIP_EN
  ,
  input  logic            trip,
  output logic            tripped
`endif
);

  logic [DT_W-1:0] r_dt_reg;
  logic [DT_W-1:0] w_dt_eff;
  logic            w_kill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_dt_reg <= DT_DEFAULT;
    else if (dt_load) r_dt_reg <= dead_time;
  end

  // A zero dead time would allow shoot-through; clamp to one cycle.
  assign w_dt_eff = (r_dt_reg == '0) ? DT_W'(1) : r_dt_reg;

`ifdef GATE_TRIP_EN
  logic r_tripped;

  // Set by trip; holds while enabled; released by a disabled cycle with
  // trip low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_tripped <= 1'b0;
    else if (trip) r_tripped <= 1'b1;
    else if (!en)  r_tripped <= 1'b0;
  end

  assign tripped = r_tripped;
  // trip is included directly so the gates drop on the very edge that sets
  // the latch rather than one cycle later.
  assign w_kill  = trip | r_tripped;
`else
  assign w_kill  = 1'b0;
`endif

  dead_time_leg #(.DT_W(DT_W)) u_leg_a (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .kill (w_kill),
    .dt   (w_dt_eff),
    .v_in (Va),
    .g_hi (ga_hi),
    .g_lo (ga_lo)
  );

  dead_time_leg #(.DT_W(DT_W)) u_leg_b (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .kill (w_kill),
    .dt   (w_dt_eff),
    .v_in (Vb),
    .g_hi (gb_hi),
    .g_lo (gb_lo)
  );

  dead_time_leg #(.DT_W(DT_W)) u_leg_c (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .kill (w_kill),
    .dt   (w_dt_eff),
    .v_in (Vc),
    .g_hi (gc_hi),
    .g_lo (gc_lo)
  );

endmodule
`default_nettype wire
